// File: rtl/carry_select_adder_16bit.sv
// Registered 16-bit carry-select adder: a 4-bit ripple slice, then three dual-ripple
// slices whose sum/carry pair is chosen by the carry selected in the slice below.
module carry_select_adder_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);

    localparam int DATA_W  = 16;
    localparam int SLICE_W = 4;
    localparam int SLICES  = DATA_W / SLICE_W;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic sum;
        logic co;
        sum = x ^ y ^ ci;
        co  = (x & y) | (ci & (x ^ y));
        return {co, sum};
    endfunction

    // Returns {carry_out, sum[3:0]}
    function automatic logic [SLICE_W:0] ripple4(input logic [SLICE_W-1:0] x,
                                                 input logic [SLICE_W-1:0] y,
                                                 input logic               ci);
        logic [SLICE_W:0] res;
        logic [1:0]       fa;
        logic             c;
        res = '0;
        c   = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            fa     = full_add(x[i], y[i], c);
            res[i] = fa[0];
            c      = fa[1];
        end
        res[SLICE_W] = c;
        return res;
    endfunction

    // carry[i] is the selected carry into slice i; carry[SLICES] is the final carry out
    logic [SLICES:0]   carry;
    logic [DATA_W-1:0] sum_p0;

    assign carry[0] = c_in;
    assign {carry[1], sum_p0[SLICE_W-1:0]} = ripple4(a[SLICE_W-1:0], b[SLICE_W-1:0], c_in);

    for (genvar g = 1; g < SLICES; g++) begin : g_slice
        logic [SLICE_W:0] res0;
        logic [SLICE_W:0] res1;

        assign res0 = ripple4(a[g*SLICE_W +: SLICE_W], b[g*SLICE_W +: SLICE_W], 1'b0);
        assign res1 = ripple4(a[g*SLICE_W +: SLICE_W], b[g*SLICE_W +: SLICE_W], 1'b1);
        assign {carry[g+1], sum_p0[g*SLICE_W +: SLICE_W]} = carry[g] ? res1 : res0;
    end

    // Stage p0 -> output register
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            s     <= sum_p0;
            c_out <= carry[SLICES];
        end
    end

endmodule

// File: tb/tb_carry_select_adder_16bit.sv
// Scoreboard bench for carry_select_adder_16bit: expected {c_out, s} is queued when a
// vector is driven and compared one rising edge later.
module tb_carry_select_adder_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [15:0] s;
    logic        c_out;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_cmp;
    int        n_err;

    carry_select_adder_16bit dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Drive one vector on the falling edge and queue the result the next rising edge must show
    task automatic drive(input string tag, input logic r, input logic [15:0] va,
                         input logic [15:0] vb, input logic vc);
        sb_entry_t e;
        @(negedge clk);
        rst  = r;
        a    = va;
        b    = vb;
        c_in = vc;
        e.tag = tag;
        e.exp = r ? 17'h0 : ({1'b0, va} + {1'b0, vb} + {16'h0, vc});
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, {c_out, s}, e.exp);
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;

        drive("reset_hold", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        drive("reset_hold2", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        drive("first_after_reset", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);

        drive("mixed_f0f1", 1'b0, 16'hF0F1, 16'hCA3F, 1'b0);
        drive("mixed_9c9d", 1'b0, 16'h9C9D, 16'h8FF0, 1'b0);
        drive("propagate_c0", 1'b0, 16'hAAAA, 16'h5555, 1'b0);
        drive("propagate_c1", 1'b0, 16'hAAAA, 16'h5555, 1'b1);
        drive("max_ops", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        drive("small_009d", 1'b0, 16'h009D, 16'h800F, 1'b0);
        drive("zero", 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive("zero_cin", 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Back-to-back stream with a one-cycle reset in the middle
        drive("stream0", 1'b0, 16'h1234, 16'h4321, 1'b0);
        drive("stream1", 1'b0, 16'h0FFF, 16'h0001, 1'b0);
        drive("stream_rst", 1'b1, 16'hFFFF, 16'h0001, 1'b1);
        drive("stream2", 1'b0, 16'h00FF, 16'h0F01, 1'b1);
        drive("stream3", 1'b0, 16'h7FFF, 16'h8000, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            drive("random", 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("drain", 17'(sb_q.size()), 17'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
